// File: rtl/ohc_rns_pkg.sv
// Shared RNS one-hot helpers: modulus default, rotation, one-hot validity and one-hot-to-binary.
// Used by the modulo adder pipeline and by the binary-to-one-hot encoder stage.
package ohc_rns_pkg;

    localparam int DEFAULT_M = 7;
    localparam int MAX_W     = 32;

    function automatic int ohc_width(input int m);
        return m;
    endfunction

    // Rotate the low m bits of v left by k, wrapping at bit m (adds k to the encoded residue).
    function automatic logic [MAX_W-1:0] rotl_mod(input logic [MAX_W-1:0] v, input int k, input int m);
        logic [MAX_W-1:0] r;
        logic [4:0]       idx;
        r = {MAX_W{1'b0}};
        for (int i = 0; i < m; i++) begin
            idx    = 5'((i + k) % m);
            r[idx] = v[i];
        end
        return r;
    endfunction

    function automatic logic onehot_is_valid(input logic [MAX_W-1:0] v, input int m);
        int cnt;
        cnt = 0;
        for (int i = 0; i < m; i++) begin
            cnt = cnt + int'(v[i]);
        end
        return (cnt == 32'sd1);
    endfunction

    function automatic int ohc_to_bin(input logic [MAX_W-1:0] v, input int m);
        int r;
        r = 0;
        for (int i = 0; i < m; i++) begin
            if (v[i]) begin
                r = r | i;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ohc_pipe_reg.sv
// One valid/ready register slice; data only loads on an accepted transfer so it is stable under stall.
module ohc_pipe_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         valid_r;
    logic [W-1:0] data_r;

    assign in_ready  = !valid_r || out_ready;
    assign out_valid = valid_r;
    assign out_data  = data_r;

    // Slice occupancy and payload register; drain and refill may happen on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= 1'b0;
            data_r  <= '0;
        end else begin
            if (in_ready) begin
                valid_r <= in_valid;
            end else begin
                valid_r <= valid_r;
            end
            if (in_valid && in_ready) begin
                data_r <= in_data;
            end else begin
                data_r <= data_r;
            end
        end
    end

endmodule

// File: rtl/ohc_mod7_adder_pipe.sv
// Two-stage modulo-M adder on one-hot residues with valid/ready backpressure.
// Optional binary result port out_bin is enabled by defining OHC_BIN_OUT_EN.
module ohc_mod7_adder_pipe
    import ohc_rns_pkg::*;
#(
    parameter int M            = DEFAULT_M,
    parameter bit CHECK_ONEHOT = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [M-1:0]          in_a,
    input  logic [M-1:0]          in_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [M-1:0]          out_ohc,
    output logic                  out_err
`ifdef OHC_BIN_OUT_EN
    ,
    output logic [$clog2(M)-1:0]  out_bin
`endif
);

    localparam int W   = ohc_width(M);
    localparam int S1W = 2 * W + 1;
`ifdef OHC_BIN_OUT_EN
    localparam int BW  = $clog2(M);
    localparam int S2W = W + 1 + BW;
`else
    localparam int S2W = W + 1;
`endif

    logic             err_s;
    logic [S1W-1:0]   s1_data_s;
    logic             s1_valid_s;
    logic             s2_ready_s;
    logic [W-1:0]     s1_a_s;
    logic [W-1:0]     s1_b_s;
    logic             s1_err_s;
    logic [MAX_W-1:0] rot_s;
    logic [W-1:0]     sum_s;
    logic [W-1:0]     ohc_s;
    logic [S2W-1:0]   s2_in_s;
    logic [S2W-1:0]   s2_data_s;

    // Operand well-formedness, captured alongside the operands in stage 1.
    always_comb begin
        if (CHECK_ONEHOT) begin
            err_s = !onehot_is_valid(MAX_W'(in_a), W) || !onehot_is_valid(MAX_W'(in_b), W);
        end else begin
            err_s = 1'b0;
        end
    end

    ohc_pipe_reg #(.W(S1W)) u_s1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   ({err_s, in_b, in_a}),
        .out_valid (s1_valid_s),
        .out_ready (s2_ready_s),
        .out_data  (s1_data_s)
    );

    assign s1_a_s   = s1_data_s[W-1:0];
    assign s1_b_s   = s1_data_s[2*W-1:W];
    assign s1_err_s = s1_data_s[2*W];

    // Adding residue k is a rotate by k; b selects exactly one rotation of a when well-formed.
    always_comb begin
        sum_s = '0;
        rot_s = '0;
        for (int k = 0; k < W; k++) begin
            rot_s = rotl_mod(MAX_W'(s1_a_s), k, W);
            if (s1_b_s[k]) begin
                sum_s = sum_s | rot_s[W-1:0];
            end else begin
                sum_s = sum_s;
            end
        end
        if (s1_err_s) begin
            ohc_s = '0;
        end else begin
            ohc_s = sum_s;
        end
    end

`ifdef OHC_BIN_OUT_EN
    logic [BW-1:0] bin_s;

    // Binary index of the one-hot sum, zero for a malformed pair.
    always_comb begin
        if (s1_err_s) begin
            bin_s = '0;
        end else begin
            bin_s = BW'(ohc_to_bin(MAX_W'(ohc_s), W));
        end
    end

    assign s2_in_s = {bin_s, s1_err_s, ohc_s};
`else
    assign s2_in_s = {s1_err_s, ohc_s};
`endif

    ohc_pipe_reg #(.W(S2W)) u_s2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s1_valid_s),
        .in_ready  (s2_ready_s),
        .in_data   (s2_in_s),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (s2_data_s)
    );

    assign out_ohc = s2_data_s[W-1:0];
    assign out_err = s2_data_s[W];
`ifdef OHC_BIN_OUT_EN
    assign out_bin = s2_data_s[W+BW:W+1];
`endif

endmodule

// File: tb/tb_ohc_mod7_adder_pipe.sv
// Randomised self-checking bench for ohc_mod7_adder_pipe against an arithmetic residue model.
// Checks out_bin too when OHC_BIN_OUT_EN is defined.
module tb_ohc_mod7_adder_pipe;

    localparam int M = 7;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [M-1:0] in_a = '0;
    logic [M-1:0] in_b = '0;
    wire          in_ready;
    wire          out_valid;
    wire          out_err;
    wire  [M-1:0] out_ohc;
`ifdef OHC_BIN_OUT_EN
    wire  [2:0]   out_bin;
`endif

    ohc_mod7_adder_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ohc   (out_ohc),
        .out_err   (out_err)
`ifdef OHC_BIN_OUT_EN
        ,
        .out_bin   (out_bin)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int sum;
        bit err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   n_out = 0;
    int   last_out_cyc = 0;
    bit   prev_stall = 1'b0;
    logic [M-1:0] held_ohc = '0;
    logic         held_err = 1'b0;
    bit   drv_done = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Residue value of a one-hot word, -1 when not exactly one bit is set.
    function automatic int ohc_val(input logic [M-1:0] v);
        if ($countones(v) != 1) return -1;
        for (int i = 0; i < M; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic exp_t model(input logic [M-1:0] a, input logic [M-1:0] b);
        exp_t e;
        int va = ohc_val(a);
        int vb = ohc_val(b);
        if (va < 0 || vb < 0) begin
            e.err = 1'b1;
            e.sum = 0;
        end else begin
            e.err = 1'b0;
            e.sum = (va + vb) % M;
        end
        return e;
    endfunction

    function automatic logic [M-1:0] oh(input int v);
        logic [M-1:0] one = 7'b0000001;
        return one << v;
    endfunction

    // Scoreboard and stall-stability monitor, sampled mid-cycle.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", out_valid, 1);
                check("stall_ohc", out_ohc, held_ohc);
                check("stall_err", out_err, held_err);
            end
            if (in_valid && in_ready) exp_q.push_back(model(in_a, in_b));
            if (out_valid && out_ready) begin
                n_out <= n_out + 1;
                last_out_cyc <= cyc;
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("sum_ohc", out_ohc, e.err ? 0 : oh(e.sum));
                    check("sum_err", out_err, e.err);
`ifdef OHC_BIN_OUT_EN
                    check("sum_bin", out_bin, e.err ? 0 : e.sum);
`endif
                end
            end
            prev_stall <= out_valid && !out_ready;
            held_ohc   <= out_ohc;
            held_err   <= out_err;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [M-1:0] a, input logic [M-1:0] b);
        bit done = 1'b0;
        int n = 0;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        while (!done && n < 50) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!done) check("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic one_shot(input string tag, input logic [M-1:0] a, input logic [M-1:0] b,
                            input logic [M-1:0] exp_ohc, input logic exp_err);
        int n = 0;
        send(a, b);
        while (!out_valid && n < 10) begin
            tick(1);
            n++;
        end
        check({tag, "_latency"}, n, 1);
        check({tag, "_ohc"}, out_ohc, exp_ohc);
        check({tag, "_err"}, out_err, exp_err);
`ifdef OHC_BIN_OUT_EN
        check({tag, "_bin"}, out_bin, exp_err ? 0 : ohc_val(exp_ohc));
`endif
        tick(1);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            tick(1);
            n++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    initial begin
        int n0;
        int c0;
        int n;

        tick(2);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_ohc", out_ohc, 0);
        check("rst_out_err", out_err, 0);
`ifdef OHC_BIN_OUT_EN
        check("rst_out_bin", out_bin, 0);
`endif
        rst = 1'b0;
        tick(1);
        check("in_ready_after_rst", in_ready, 1);
        out_ready = 1'b1;

        one_shot("basic_3p2", 7'b0001000, 7'b0000100, 7'b0100000, 1'b0);
        one_shot("wrap_6p6", 7'b1000000, 7'b1000000, 7'b0100000, 1'b0);
        one_shot("wrap_4p3", 7'b0010000, 7'b0001000, 7'b0000001, 1'b0);
        one_shot("zero_0p5", 7'b0000001, 7'b0100000, 7'b0100000, 1'b0);
        one_shot("bad_zero", 7'b0000000, 7'b0000010, 7'b0000000, 1'b1);
        one_shot("bad_two", 7'b0000011, 7'b0000010, 7'b0000000, 1'b1);
        drain();

        // Backpressure: 0+1..0+6 with out_ready held low for three edges once results appear.
        n0 = n_out;
        fork
            begin
                for (int v = 1; v <= 6; v++) send(oh(0), oh(v));
            end
            begin
                n = 0;
                while (!out_valid && n < 20) begin
                    tick(1);
                    n++;
                end
                out_ready = 1'b0;
                tick(2);
                @(negedge clk);
                check("bp_in_ready", in_ready, 0);
                check("bp_out_valid", out_valid, 1);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        check("bp_count", n_out - n0, 6);

        // Reset with two results in flight discards both.
        out_ready = 1'b0;
        send(oh(2), oh(3));
        send(oh(5), oh(1));
        rst = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_ohc", out_ohc, 0);
        exp_q.delete();
        n0 = n_out;
        tick(2);
        check("midrst_edge_valid", out_valid, 0);
        rst = 1'b0;
        out_ready = 1'b1;
        tick(5);
        check("midrst_no_emit", n_out - n0, 0);

        // Throughput: 100 back-to-back pairs complete 101 cycles after the first transfer.
        n0 = n_out;
        c0 = cyc;
        for (int i = 0; i < 100; i++) send(oh($urandom_range(0, 6)), oh($urandom_range(0, 6)));
        drain();
        check("tp_count", n_out - n0, 100);
        check("tp_cycles", last_out_cyc - c0, 101);

        // Random backpressure with occasional malformed operands.
        n0 = n_out;
        drv_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    if ($urandom_range(0, 7) == 0)
                        send(7'($urandom_range(0, 127)), oh($urandom_range(0, 6)));
                    else
                        send(oh($urandom_range(0, 6)), oh($urandom_range(0, 6)));
                end
                drv_done = 1'b1;
            end
            begin
                while (!drv_done) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    tick(1);
                end
                out_ready = 1'b1;
            end
        join
        drain();
        check("rand_count", n_out - n0, 60);
        check("queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
